// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the data-memory / MMIO stage: IO window base, register
// offsets, TX status bit positions and the IO register decode helper.
package dmem_mmio_pkg;

    localparam int DATA_W = 32;

    localparam logic [23:0] IO_BASE_HI = 24'hFFFFFF;

    localparam logic [7:0] IO_GPIO   = 8'h00;
    localparam logic [7:0] IO_CYCLE  = 8'h04;
    localparam logic [7:0] IO_TXDATA = 8'h08;
    localparam logic [7:0] IO_TXSTAT = 8'h0C;
    localparam logic [7:0] IO_TXDROP = 8'h10;

    localparam int TXSTAT_EMPTY     = 0;
    localparam int TXSTAT_FULL      = 1;
    localparam int TXSTAT_COUNT_LSB = 8;

    typedef enum logic [2:0] {
        REG_GPIO,
        REG_CYCLE,
        REG_TXDATA,
        REG_TXSTAT,
        REG_TXDROP,
        REG_NONE
    } io_reg_e;

    // Offset must already have its byte-lane bits cleared.
    function automatic io_reg_e decode_io(input logic [7:0] offset);
        case (offset)
            IO_GPIO:   return REG_GPIO;
            IO_CYCLE:  return REG_CYCLE;
            IO_TXDATA: return REG_TXDATA;
            IO_TXSTAT: return REG_TXSTAT;
            IO_TXDROP: return REG_TXDROP;
            default:   return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/dmem_mmio_tx_fifo.sv
// Byte-wide circular TX FIFO: wrapping rd/wr pointers plus an occupancy count.
// A push into a full FIFO is accepted only when a pop frees a slot that cycle.
module tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;
    assign head    = empty ? 8'h00 : mem[rd_ptr];

    // NOTE: storage arrays carry no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dmem_mmio.sv
// Data-memory stage: word RAM plus MMIO window (GPIO, cycle counter, TX FIFO).
// Optional TX drop counter at offset 0x10 is built when DMEM_TX_DROP_CNT_EN is defined.
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int RAM_WORDS  = 256,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] writedata,
    input  logic              memwrite,
    output logic [DATA_W-1:0] readdata,
    output logic [DATA_W-1:0] gpio_out,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_W-1:0] ram [RAM_WORDS];
    logic [RAM_AW-1:0] ram_idx;
    logic              io_hit;
    io_reg_e           sel;
    logic [DATA_W-1:0] cycle_cnt;
    logic [DATA_W-1:0] txstat;
    logic [DATA_W-1:0] drop_rd;

    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic              fifo_drop;
    logic              tx_push;
    logic              tx_pop;

    assign ram_idx = addr[RAM_AW+1:2];
    assign io_hit  = (addr[31:8] == IO_BASE_HI);
    assign sel     = io_hit ? decode_io({addr[7:2], 2'b00}) : REG_NONE;
    assign tx_push = memwrite & (sel == REG_TXDATA);
    assign tx_pop  = tx_valid & tx_ready;
    assign tx_valid = ~fifo_empty;

    tx_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_push),
        .push_data (writedata[7:0]),
        .pop       (tx_pop),
        .head      (tx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .drop      (fifo_drop)
    );

    always_ff @(posedge clk) begin
        if (memwrite && !io_hit) begin
            ram[ram_idx] <= writedata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpio_out  <= '0;
            cycle_cnt <= '0;
        end else begin
            if (memwrite && sel == REG_GPIO) gpio_out <= writedata;
            // A write clears the counter and takes priority over the increment.
            if (memwrite && sel == REG_CYCLE) cycle_cnt <= '0;
            else                              cycle_cnt <= cycle_cnt + 1'b1;
        end
    end

`ifdef DMEM_TX_DROP_CNT_EN
    logic [15:0] drop_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (memwrite && sel == REG_TXDROP) begin
            drop_cnt <= '0;
        end else if (fifo_drop && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

    assign drop_rd = {16'h0000, drop_cnt};

    logic unused_bits;
    assign unused_bits = ^addr[1:0];
`else
    assign drop_rd = '0;

    logic unused_bits;
    assign unused_bits = ^{addr[1:0], fifo_drop};
`endif

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        txstat                               = '0;
        txstat[TXSTAT_COUNT_LSB +: 8]        = 8'(fifo_count);
        txstat[TXSTAT_FULL]                  = fifo_full;
        txstat[TXSTAT_EMPTY]                 = fifo_empty;
    end

    always_comb begin
        readdata = '0;
        if (!io_hit) begin
            readdata = ram[ram_idx];
        end else begin
            case (sel)
                REG_GPIO:   readdata = gpio_out;
                REG_CYCLE:  readdata = cycle_cnt;
                REG_TXSTAT: readdata = txstat;
                REG_TXDROP: readdata = drop_rd;
                default:    readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed, table-driven bench for dmem_mmio: RAM aliasing, GPIO, cycle counter,
// TX FIFO fill/drain/full-with-pop, and asynchronous reset flush.
module tb_dmem_mmio;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic        memwrite;
    logic [31:0] readdata;
    logic [31:0] gpio_out;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int n_vec = 0;
    int n_err = 0;

`ifdef DMEM_TX_DROP_CNT_EN
    localparam logic [31:0] DROP_EXP = 32'd1;
`else
    localparam logic [31:0] DROP_EXP = 32'd0;
`endif

    localparam logic [31:0] A_GPIO = 32'hFFFF_FF00;
    localparam logic [31:0] A_CYC  = 32'hFFFF_FF04;
    localparam logic [31:0] A_TXD  = 32'hFFFF_FF08;
    localparam logic [31:0] A_STAT = 32'hFFFF_FF0C;
    localparam logic [31:0] A_DROP = 32'hFFFF_FF10;

    always #5 clk = ~clk;

    dmem_mmio dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .writedata (writedata),
        .memwrite  (memwrite),
        .readdata  (readdata),
        .gpio_out  (gpio_out),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rdy;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        chk_tx;
        logic        exp_valid;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic we, logic [31:0] a, logic [31:0] wd, logic rdy,
                                logic crd, logic [31:0] erd,
                                logic ctx, logic ev, logic [7:0] ed);
        vec_t v;
        v.we = we; v.addr = a; v.wdata = wd; v.rdy = rdy;
        v.chk_rd = crd; v.exp_rd = erd;
        v.chk_tx = ctx; v.exp_valid = ev; v.exp_data = ed;
        return v;
    endfunction

    function automatic vec_t rd(logic [31:0] a, logic [31:0] e);
        return mk(1'b0, a, 32'h0, 1'b0, 1'b1, e, 1'b0, 1'b0, 8'h00);
    endfunction

    function automatic vec_t wr(logic [31:0] a, logic [31:0] d);
        return mk(1'b1, a, d, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive at the falling edge, sample 1ns later, then advance one full cycle.
    task automatic apply(input vec_t v, input string tag);
        memwrite  = v.we;
        addr      = v.addr;
        writedata = v.wdata;
        tx_ready  = v.rdy;
        #1;
        if (v.chk_rd) check({tag, " readdata"}, readdata, v.exp_rd);
        if (v.chk_tx) begin
            check({tag, " tx_valid"}, 32'(tx_valid), 32'(v.exp_valid));
            check({tag, " tx_data"},  32'(tx_data),  32'(v.exp_data));
        end
        @(negedge clk);
        memwrite = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;

        // ---- table: reset state, RAM, GPIO, decode, FIFO fill/drain ----
        vecs.push_back(rd(A_GPIO, 32'h0));
        vecs.push_back(rd(A_STAT, 32'h0000_0001));
        vecs.push_back(rd(A_DROP, 32'h0));
        vecs.push_back(rd(A_TXD,  32'h0));
        vecs.push_back(wr(32'h0000_0010, 32'hDEAD_BEEF));
        vecs.push_back(rd(32'h0000_0010, 32'hDEAD_BEEF));
        vecs.push_back(rd(32'h0000_0410, 32'hDEAD_BEEF));
        vecs.push_back(rd(32'h0000_0013, 32'hDEAD_BEEF));
        vecs.push_back(wr(32'h0000_0FF0, 32'h1234_5678));
        vecs.push_back(rd(32'h0000_03F0, 32'h1234_5678));
        vecs.push_back(rd(32'h0000_0010, 32'hDEAD_BEEF));
        // Same-cycle load of a register being written returns the old value.
        vecs.push_back(mk(1'b1, A_GPIO, 32'h0000_A5A5, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 8'h00));
        vecs.push_back(rd(A_GPIO, 32'h0000_A5A5));
        vecs.push_back(rd(32'hFFFF_FF03, 32'h0000_A5A5));
        vecs.push_back(wr(32'hFFFF_FF14, 32'hFFFF_FFFF));
        vecs.push_back(rd(32'hFFFF_FF14, 32'h0));
        vecs.push_back(wr(A_STAT, 32'hFFFF_FFFF));
        vecs.push_back(rd(A_STAT, 32'h0000_0001));
        vecs.push_back(wr(32'hFFFF_FE10, 32'h1111_1111));
        vecs.push_back(rd(32'h0000_0210, 32'h1111_1111));
        vecs.push_back(rd(A_GPIO, 32'h0000_A5A5));
        for (int k = 1; k <= 9; k++) begin
            vecs.push_back(mk(1'b1, A_TXD, 32'hABCD_EF00 | 32'(k), 1'b0, 1'b1, 32'h0,
                              1'b1, (k > 1), (k > 1) ? 8'h01 : 8'h00));
        end
        vecs.push_back(rd(A_STAT, 32'h0000_0802));
        vecs.push_back(rd(A_DROP, DROP_EXP));
        for (int k = 1; k <= 8; k++) begin
            vecs.push_back(mk(1'b0, A_STAT, 32'h0, 1'b1, 1'b1,
                              (32'(9 - k) << 8) | ((k == 1) ? 32'h2 : 32'h0),
                              1'b1, 1'b1, 8'(k)));
        end
        vecs.push_back(mk(1'b0, A_STAT, 32'h0, 1'b0, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 8'h00));

        // ---- reset ----
        rst = 1'b1; memwrite = 1'b0; addr = A_CYC; writedata = 32'h0; tx_ready = 1'b0;
        #1;
        check("reset tx_valid", 32'(tx_valid), 32'h0);
        check("reset gpio_out", gpio_out, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // ---- cycle counter ----
        repeat (10) @(negedge clk);
        #1 check("cycle at reset+10", readdata, 32'd10);
        apply(mk(1'b1, A_CYC, 32'h0000_1234, 1'b0, 1'b1, 32'd10, 1'b0, 1'b0, 8'h00), "cycle write");
        repeat (2) @(negedge clk);
        apply(rd(A_CYC, 32'd2), "cycle after clear");
        force dut.cycle_cnt = 32'hFFFF_FFFF;
        #1 release dut.cycle_cnt;
        apply(rd(A_CYC, 32'hFFFF_FFFF), "cycle max");
        apply(rd(A_CYC, 32'h0), "cycle wrap");

        // ---- table ----
        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));
        check("gpio_out port", gpio_out, 32'h0000_A5A5);

        // ---- full FIFO, push with same-cycle pop ----
        for (int k = 0; k < 8; k++) apply(wr(A_TXD, 32'h10 + 32'(k)), "fillA");
        v = mk(1'b1, A_TXD, 32'h55, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 8'h10);
        apply(v, "full push+pop");
        v = mk(1'b0, A_STAT, 32'h0, 1'b0, 1'b1, 32'h0000_0802, 1'b1, 1'b1, 8'h11);
        apply(v, "after push+pop");
        apply(rd(A_DROP, DROP_EXP), "drops unchanged");
        for (int k = 0; k < 8; k++) begin
            v = mk(1'b0, A_STAT, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1,
                   (k == 7) ? 8'h55 : 8'(8'h11 + k));
            apply(v, $sformatf("drainA%0d", k));
        end
        apply(mk(1'b0, A_STAT, 32'h0, 1'b0, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 8'h00), "drainA done");

        // ---- asynchronous reset mid-operation ----
        for (int k = 0; k < 3; k++) apply(wr(A_TXD, 32'hA1 + 32'(k)), "fillB");
        addr = A_STAT; tx_ready = 1'b0;
        #1 check("pre-reset tx_valid", 32'(tx_valid), 32'h1);
        #1 rst = 1'b1;
        #1;
        check("async rst tx_valid", 32'(tx_valid), 32'h0);
        check("async rst tx_data", 32'(tx_data), 32'h0);
        check("async rst gpio_out", gpio_out, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        apply(rd(A_STAT, 32'h0000_0001), "post-reset status");
        apply(rd(A_DROP, 32'h0), "post-reset drops");
        apply(rd(32'h0000_0410, 32'hDEAD_BEEF), "ram survives reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
